// File: rtl/id_ex_elastic_pkg.sv
// Shared widths and NOP encodings for the elastic ID->EX stage.
// The top module takes its parameter defaults from here.
package id_ex_elastic_pkg;
   localparam int AluOpBus   = 8;
   localparam int AluSelBus  = 3;
   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;

   localparam logic [RegBus-1:0]    ZeroWord    = '0;
   localparam logic [AluOpBus-1:0]  EXE_NOP_OP  = 8'h00;
   localparam logic [AluSelBus-1:0] EXE_RES_NOP = 3'b000;
endpackage

// File: rtl/id_ex_elastic_pipe_slot.sv
// One payload slot with its valid bit. Clear beats load, so an invalid slot always holds zero.
module id_ex_elastic_pipe_slot #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_clr,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q,
   output logic         o_vld
);
   logic [W-1:0] r_q;
   logic         r_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q   <= '0;
         r_vld <= 1'b0;
      end else if (i_clr) begin
         r_q   <= '0;
         r_vld <= 1'b0;
      end else if (i_load) begin
         r_q   <= i_d;
         r_vld <= 1'b1;
      end
   end

   assign o_q   = r_q;
   assign o_vld = r_vld;
endmodule

// File: rtl/id_ex_elastic.sv
// Elastic ID->EX register: main slot drives EX, skid slot absorbs the one instruction
// accepted while EX stalls, so id_ready depends only on registered state.
module id_ex_elastic
   import id_ex_elastic_pkg::*;
#(
   parameter int ALUOP_W  = AluOpBus,
   parameter int ALUSEL_W = AluSelBus,
   parameter int DATA_W   = RegBus,
   parameter int RADDR_W  = RegAddrBus
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                id_valid,
   output logic                id_ready,
   input  logic [ALUOP_W-1:0]  id_aluop,
   input  logic [ALUSEL_W-1:0] id_alusel,
   input  logic [DATA_W-1:0]   id_reg1,
   input  logic [DATA_W-1:0]   id_reg2,
   input  logic [RADDR_W-1:0]  id_wd,
   input  logic                id_wreg,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [ALUOP_W-1:0]  ex_aluop,
   output logic [ALUSEL_W-1:0] ex_alusel,
   output logic [DATA_W-1:0]   ex_reg1,
   output logic [DATA_W-1:0]   ex_reg2,
   output logic [RADDR_W-1:0]  ex_wd,
   output logic                ex_wreg
);
   localparam int PAY_W = ALUOP_W + ALUSEL_W + 2 * DATA_W + RADDR_W + 1;

   logic [PAY_W-1:0] w_id_pay;
   logic [PAY_W-1:0] w_main_d;
   logic [PAY_W-1:0] w_main_q;
   logic [PAY_W-1:0] w_skid_q;
   logic             w_main_vld;
   logic             w_skid_vld;
   logic             w_accept;
   logic             w_consume;
   logic             w_main_load;
   logic             w_main_clr;
   logic             w_skid_load;
   logic             w_skid_clr;

   assign w_id_pay  = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};

   assign id_ready  = !rst && !w_skid_vld;
   assign ex_valid  = w_main_vld;
   assign w_accept  = id_valid && id_ready;
   assign w_consume = w_main_vld && ex_ready;

   // Main refills from skid first (it is older); otherwise from ID.
   assign w_main_d    = w_skid_vld ? w_skid_q : w_id_pay;
   assign w_main_load = !flush &&
                        ((!w_main_vld && w_accept) ||
                         (w_consume && (w_skid_vld || w_accept)));
   assign w_main_clr  = flush || (w_consume && !w_skid_vld && !w_accept);

   assign w_skid_load = !flush && w_main_vld && !w_consume && w_accept;
   assign w_skid_clr  = flush || (w_consume && w_skid_vld);

   id_ex_elastic_pipe_slot #(.W(PAY_W)) u_main (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_main_load),
      .i_clr  (w_main_clr),
      .i_d    (w_main_d),
      .o_q    (w_main_q),
      .o_vld  (w_main_vld)
   );

   id_ex_elastic_pipe_slot #(.W(PAY_W)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_skid_load),
      .i_clr  (w_skid_clr),
      .i_d    (w_id_pay),
      .o_q    (w_skid_q),
      .o_vld  (w_skid_vld)
   );

   assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg} = w_main_q;

   a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst)
      !(w_skid_vld && !w_main_vld));
endmodule

// File: tb/tb_id_ex_elastic.sv
// Directed and scoreboard-checked stimulus for the elastic ID->EX stage.
module tb_id_ex_elastic;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [7:0]  id_aluop;
   logic [2:0]  id_alusel;
   logic [31:0] id_reg1;
   logic [31:0] id_reg2;
   logic [4:0]  id_wd;
   logic        id_wreg;
   logic        ex_valid;
   logic        ex_ready;
   logic [7:0]  ex_aluop;
   logic [2:0]  ex_alusel;
   logic [31:0] ex_reg1;
   logic [31:0] ex_reg2;
   logic [4:0]  ex_wd;
   logic        ex_wreg;

   logic [80:0] ex_pay;
   assign ex_pay = {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg};

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   id_ex_elastic dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_aluop(id_aluop), .id_alusel(id_alusel),
      .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
      .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] r1);
      id_valid  = v;
      id_aluop  = op;
      id_alusel = op[2:0];
      id_reg1   = r1;
      id_reg2   = ~r1;
      id_wd     = op[4:0];
      id_wreg   = op[0];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [80:0] q[$];
   logic [80:0] prev_pay;
   logic        prev_stall;
   logic        acc;
   logic        con;

   initial begin
      rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
      drive(1'b1, 8'($urandom), $urandom);

      // Reset held with live inputs
      #100;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_pay", ex_pay, 0);
      chk("rst_id_ready", id_ready, 0);
      drive(1'b0, 8'h00, 32'h0);
      rst = 1'b0;
      #1;
      chk("rel_id_ready", id_ready, 1);
      tick();

      // Streaming at full rate
      ex_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'h21 + 8'(i), 32'h100 + i);
         tick();
         chk("stream_valid", ex_valid, 1);
         chk("stream_aluop", ex_aluop, 8'h21 + 8'(i));
         chk("stream_ready", id_ready, 1);
      end
      drive(1'b0, 8'h00, 32'h0);
      tick();
      chk("drain_valid", ex_valid, 0);
      chk("drain_pay", ex_pay, 0);

      // Back-pressure fills the skid slot
      ex_ready = 1'b0;
      drive(1'b1, 8'h25, 32'h25);
      tick();
      chk("bp1_aluop", ex_aluop, 8'h25);
      chk("bp1_ready", id_ready, 1);
      drive(1'b1, 8'h26, 32'h26);
      tick();
      chk("bp2_aluop", ex_aluop, 8'h25);
      chk("bp2_ready", id_ready, 0);
      drive(1'b0, 8'h00, 32'h0);
      tick();
      chk("bp_hold_aluop", ex_aluop, 8'h25);
      chk("bp_hold_reg1", ex_reg1, 32'h25);
      ex_ready = 1'b1;
      tick();
      chk("bp_out2_aluop", ex_aluop, 8'h26);
      chk("bp_out2_valid", ex_valid, 1);
      chk("bp_ready_back", id_ready, 1);
      tick();
      chk("bp_empty", ex_valid, 0);

      // Flush a full stage with a same-cycle input
      ex_ready = 1'b0;
      drive(1'b1, 8'h31, 32'hDEADBEEF);
      tick();
      drive(1'b1, 8'h32, 32'h12345678);
      tick();
      chk("fl_full_ready", id_ready, 0);
      flush = 1'b1;
      drive(1'b1, 8'h33, 32'hCAFEF00D);
      tick();
      chk("fl_valid", ex_valid, 0);
      chk("fl_pay", ex_pay, 0);
      chk("fl_ready", id_ready, 1);
      flush = 1'b0;
      drive(1'b0, 8'h00, 32'h0);
      tick();
      chk("fl_no_ghost", ex_valid, 0);
      chk("fl_no_ghost_reg1", ex_reg1, 0);

      // Async reset between edges while full
      drive(1'b1, 8'h41, 32'hA5A5A5A5);
      tick();
      drive(1'b1, 8'h42, 32'h5A5A5A5A);
      tick();
      drive(1'b0, 8'h00, 32'h0);
      chk("ar_pre_valid", ex_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", ex_valid, 0);
      chk("ar_pay", ex_pay, 0);
      chk("ar_ready", id_ready, 0);
      rst = 1'b0;
      #1;
      chk("ar_ready_rel", id_ready, 1);
      tick();
      ex_ready = 1'b1;
      tick();
      chk("ar_empty_after", ex_valid, 0);

      // Random valid/ready against a FIFO model
      prev_stall = 1'b0;
      prev_pay   = '0;
      for (int c = 0; c < 10000; c++) begin
         chk("rnd_valid", ex_valid, q.size() > 0);
         chk("rnd_ready", id_ready, q.size() < 2);
         if (q.size() > 0) chk("rnd_pay", ex_pay, q[0]);
         else              chk("rnd_nop", ex_pay, 0);
         if (prev_stall) chk("rnd_stable", ex_pay, prev_pay);
         drive(1'($urandom_range(0, 3) != 0), 8'($urandom), $urandom);
         ex_ready = 1'($urandom_range(0, 2) != 0);
         acc = id_valid && (q.size() < 2);
         con = ex_ready && (q.size() > 0);
         prev_stall = (q.size() > 0) && !ex_ready;
         prev_pay   = ex_pay;
         if (con) void'(q.pop_front());
         if (acc) q.push_back({id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg});
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
